flatten_stream: RTL

FLATTEN_STREAM -- requirements
Module: flatten_stream

---
 rtl/flatten_stream_if.sv | 28 ++
 rtl/flatten_stream.sv | 120 ++++++++++++
 2 files changed

// File: rtl/flatten_stream_if.sv
// Bundle for the pixel input and the serialized feature output of flatten_stream.
// Handshake: a pixel moves on a rising clk edge where in_valid and in_ready are
// both 1; in_valid with in_ready low is ignored (the source holds or retries),
// in_ready never depends on in_valid, and the feature side is a push-only stream
// (feat_valid qualifies feat_data, no back-pressure).
interface flatten_stream_if #(
    parameter int CH_NUM    = 16,
    parameter int DATA_BITS = 8
);
    logic                          in_valid;
    logic                          in_ready;
    logic [CH_NUM*DATA_BITS-1:0]   in_data;
    logic                          feat_valid;
    logic signed [DATA_BITS-1:0]   feat_data;
    logic                          frame_done;

    // Source/sink side (testbench or upstream/downstream glue).
    modport master (
        output in_valid, in_data,
        input  in_ready, feat_valid, feat_data, frame_done
    );

    // The flatten block itself.
    modport slave (
        input  in_valid, in_data,
        output in_ready, feat_valid, feat_data, frame_done
    );
endinterface

// File: rtl/flatten_stream.sv
// Flatten stage: buffers up to two packed pixels in ping-pong slots and
// serializes them one channel byte per cycle in HWC order, pulsing frame_done
// on the last byte of every PIX_NUM-pixel frame.
module flatten_stream #(
    parameter int PIX_NUM   = 196,
    parameter int CH_NUM    = 16,
    parameter int DATA_BITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    flatten_stream_if.slave  bus,
    output logic             dbg_state
);
    localparam int CH_W  = (CH_NUM  > 1) ? $clog2(CH_NUM)  : 1;
    localparam int PIX_W = (PIX_NUM > 1) ? $clog2(PIX_NUM) : 1;

    // IDLE: no slot loaded. EMIT: streaming channel ch_q of the read slot.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t                       state_q, state_d;
    logic [1:0]                   count_q, count_d;
    logic                         wr_ptr_q, rd_ptr_q;
    logic [CH_W-1:0]              ch_q, ch_d;
    logic [PIX_W-1:0]             pix_q, pix_d;
    logic [CH_NUM*DATA_BITS-1:0]  slot_q [2];

    logic                         accept;
    logic                         emit;
    logic                         last_ch;
    logic                         last_pix;
    logic                         free_slot;
    logic signed [DATA_BITS-1:0]  byte_sel;

    logic                         feat_valid_q;
    logic signed [DATA_BITS-1:0]  feat_data_q;
    logic                         frame_done_q;

    // Ready comes only from the registered occupancy (and reset), never from in_valid.
    assign bus.in_ready = (count_q != 2'd2) && !rst;
    assign accept       = bus.in_valid && bus.in_ready;

    assign emit      = (state_q == S_EMIT);
    assign last_ch   = (ch_q == CH_W'(CH_NUM - 1));
    assign last_pix  = (pix_q == PIX_W'(PIX_NUM - 1));
    assign free_slot = emit && last_ch;

    assign bus.feat_valid = feat_valid_q;
    assign bus.feat_data  = feat_data_q;
    assign bus.frame_done = frame_done_q;
    assign dbg_state      = state_q;

    // Channel multiplexer: pick byte ch_q of the slot being read.
    always_comb begin
        byte_sel = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            if (ch_q == CH_W'(c)) begin
                byte_sel = slot_q[rd_ptr_q][c*DATA_BITS +: DATA_BITS];
            end
        end
    end

    // Next-state: channel/pixel counters, occupancy and serializer state.
    always_comb begin
        state_d = state_q;
        count_d = count_q + {1'b0, accept} - {1'b0, free_slot};
        ch_d    = ch_q;
        pix_d   = pix_q;

        if (emit) begin
            if (last_ch) begin
                ch_d  = '0;
                pix_d = last_pix ? '0 : pix_q + 1'b1;
            end else begin
                ch_d = ch_q + 1'b1;
            end
        end

        // A slot freed while the other one is full rolls straight into it.
        case (state_q)
            S_IDLE:  if (count_d != 2'd0) state_d = S_EMIT;
            S_EMIT:  if (count_d == 2'd0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control registers and registered feature outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            count_q      <= 2'd0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            ch_q         <= '0;
            pix_q        <= '0;
            feat_valid_q <= 1'b0;
            feat_data_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            ch_q         <= ch_d;
            pix_q        <= pix_d;
            if (accept)    wr_ptr_q <= !wr_ptr_q;
            if (free_slot) rd_ptr_q <= !rd_ptr_q;
            feat_valid_q <= emit;
            feat_data_q  <= emit ? byte_sel : '0;
            frame_done_q <= free_slot && last_pix;
        end
    end

    // Pixel storage; only ever written into the slot not being read.
    always_ff @(posedge clk) begin
        if (accept) begin
            slot_q[wr_ptr_q] <= bus.in_data;
        end
    end
endmodule
